// File: rtl/uart_rx_parity_pkg.sv
// Shared UART receiver definitions: FSM state encodings and default line constants.
package uart_rx_parity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // 100 MHz system clock at 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_parity_if.sv
// Valid/ready byte interface between the UART receiver and the CPU I/O mapper.
interface uart_rx_parity_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_parity_bit_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs; both flops reset to RESET_VAL.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with parity check, per-frame error flags and a valid/ready output holding register.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | line idle, waiting for a low level on the synchronised rx
//  ST_START  | half-bit wait, then confirm start bit (reject glitches)
//  ST_DATA   | sample DATA_BITS data bits, LSB first, once per bit time
//  ST_PARITY | sample parity bit and compare with running XOR
//  ST_STOP   | sample stop bit, request commit of the frame
//  ST_BREAK  | stop bit was low; wait for line to return high
module uart_rx_parity
  import uart_rx_parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  uart_rx_parity_if.master   rx_if,
  output logic               overrun,
  output logic               busy
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rxs;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = HALF_TC;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = FULL_TC;
          bit_d   = LAST_BIT;
          par_d   = 1'(PARITY_ODD);
          perr_d  = 1'b0;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rxs;
          cnt_d   = FULL_TC;
          if (bit_q == '0) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          perr_d  = par_q ^ rxs;
          cnt_d   = FULL_TC;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ferr_d   = ~rxs;
          commit_d = 1'b1;
          // Back to IDLE at mid-stop so a start bit half a bit later is still caught
          state_d  = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = overrun_q;

    if (commit_q) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_d     = shreg_q;
        perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
        ferr_out_d = ferr_q;
        valid_d    = 1'b1;
        if (valid_q) begin
          overrun_d = 1'b0;
        end
      end else begin
        // Consumer still holds the previous byte: drop the new frame, keep the old one
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.rx_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_out_q;
  assign rx_if.frame_err  = ferr_out_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: frame vector table plus break, glitch, overrun and reset sequences.
module tb_uart_rx_parity;
  localparam int CPB     = 16;
  localparam int LATENCY = 2 + CPB / 2 + (8 + 1 + 1) * CPB + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic overrun;
  logic busy;

  uart_rx_parity_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_parity #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_EN    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_if   (rx_if.master),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rises = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rx_if.rx_valid && !prev_v) rises++;
    prev_v = rx_if.rx_valid;
  end

  int pass_cnt = 0;
  int total    = 0;
  int start_cyc = 0;
  logic send_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] cur_d;
  logic       cur_p;
  logic       cur_s;
  int         cur_len;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int stop_len);
    send_busy = 1'b1;
    @(posedge clk); #1;
    rx = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      #1 rx = d[b];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = p;
    repeat (CPB) @(posedge clk);
    #1 rx = s;
    repeat (stop_len) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    send_busy = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rx_if.rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL %s: rx_valid not seen within 400 cycles", name);
    end
  endtask

  task automatic wait_send_done();
    for (int n = 0; n < 2000 && send_busy; n++) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int r0;

    //            data   par  stop exp    perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[6] = '{8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};

    rx_if.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data",    rx_if.rx_data,    0);
    chk("reset_valid",   rx_if.rx_valid,   0);
    chk("reset_perr",    rx_if.parity_err, 0);
    chk("reset_ferr",    rx_if.frame_err,  0);
    chk("reset_overrun", overrun,          0);
    chk("reset_busy",    busy,             0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_d = vecs[i].data; cur_p = vecs[i].par; cur_s = vecs[i].stop; cur_len = CPB;
      fork send_frame(cur_d, cur_p, cur_s, cur_len); join_none
      wait_valid($sformatf("vec%0d_valid", i), ok);
      if (ok) begin
        chk($sformatf("vec%0d_latency", i), cyc - start_cyc, LATENCY);
        chk($sformatf("vec%0d_data", i), rx_if.rx_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_perr", i), rx_if.parity_err, vecs[i].exp_perr);
        chk($sformatf("vec%0d_ferr", i), rx_if.frame_err, vecs[i].exp_ferr);
        @(negedge clk);
        chk($sformatf("vec%0d_pulse", i), rx_if.rx_valid, 0);
      end
      wait_send_done();
    end

    // Stop bit low with the line held low: one errored frame, no retrigger
    r0 = rises;
    cur_d = 8'h3C; cur_p = 1'b0; cur_s = 1'b0; cur_len = 40;
    fork send_frame(cur_d, cur_p, cur_s, cur_len); join_none
    wait_valid("break_valid", ok);
    if (ok) begin
      chk("break_data", rx_if.rx_data, 8'h3C);
      chk("break_ferr", rx_if.frame_err, 1);
      chk("break_perr", rx_if.parity_err, 0);
    end
    wait_send_done();
    repeat (20) @(negedge clk);
    chk("break_single_frame", rises - r0, 1);
    fork send_frame(8'h55, 1'b0, 1'b1, CPB); join_none
    wait_valid("after_break_valid", ok);
    if (ok) begin
      chk("after_break_data", rx_if.rx_data, 8'h55);
      chk("after_break_ferr", rx_if.frame_err, 0);
      chk("after_break_perr", rx_if.parity_err, 0);
    end
    wait_send_done();

    // Short low glitch on an idle line
    r0 = rises;
    @(posedge clk); #1 rx = 1'b0;
    repeat (6) @(posedge clk);
    chk("glitch_busy_start", busy, 1);
    #1 rx = 1'b1;
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);
    chk("glitch_busy_idle", busy, 0);
    repeat (20) @(negedge clk);
    chk("glitch_no_valid", rises - r0, 0);

    // Overrun: consumer stalled across two frames
    rx_if.rx_ready = 1'b0;
    fork send_frame(8'h11, 1'b0, 1'b1, CPB); join_none
    wait_valid("ovr_first_valid", ok);
    wait_send_done();
    chk("ovr_before", overrun, 0);
    send_frame(8'h22, 1'b0, 1'b1, CPB);
    repeat (4) @(negedge clk);
    chk("ovr_valid_held", rx_if.rx_valid, 1);
    chk("ovr_data_kept", rx_if.rx_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", rx_if.rx_valid, 0);
    chk("ovr_flag_cleared", overrun, 0);

    // Reset in the middle of a frame while a byte is still held
    rx_if.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, CPB);
    @(negedge clk);
    chk("rst_pre_valid", rx_if.rx_valid, 1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB * 4 + 8) @(posedge clk);
    #2;
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rx_if.rx_valid, 0);
    chk("rst_mid_data",  rx_if.rx_data,  0);
    chk("rst_mid_busy",  busy,           0);
    chk("rst_mid_ovr",   overrun,        0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    fork send_frame(8'hC3, 1'b0, 1'b1, CPB); join_none
    wait_valid("post_rst_valid", ok);
    if (ok) begin
      chk("post_rst_latency", cyc - start_cyc, LATENCY);
      chk("post_rst_data", rx_if.rx_data, 8'hC3);
      chk("post_rst_perr", rx_if.parity_err, 0);
      chk("post_rst_ferr", rx_if.frame_err, 0);
    end
    wait_send_done();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
